// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: computes {cout, sum} = a + b + cin one bit per clock,
//   LSB first, using a single full-adder cell and a carry flop.
//
// Parameters
//   WIDTH      operand/result width in bits (2..32)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   start      request a new addition (accepted in IDLE or DONE)
//   a, b, cin  operands, captured only when start is accepted
//   busy       high while the bit-serial computation runs (RUN state)
//   done       one-cycle pulse marking a new valid result (DONE state)
//   sum        registered result, low WIDTH bits of a+b+cin
//   cout       registered carry-out, bit WIDTH of a+b+cin
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DONE) for observation
//
// Handshake: start is a level sampled at each rising edge. It is accepted
// only in IDLE or DONE; while busy is high it is ignored. Exactly WIDTH
// edges after acceptance the result lands on sum/cout and done pulses for
// one cycle. Holding start high chains operations with no idle gap.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter only needs to reach WIDTH-1 (the last bit index).
    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             carry;

    // Single full-adder cell working on the current LSBs.
    logic             sbit;
    logic             cnext;
    logic [WIDTH-1:0] acc_next;

    assign sbit     = a_sr[0] ^ b_sr[0] ^ carry;
    assign cnext    = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign acc_next = {sbit, acc[WIDTH-1:1]};

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here.
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= cnext;
                    acc   <= acc_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        // Last bit: publish the completed accumulator and carry.
                        sum   <= acc_next;
                        cout  <= cnext;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH = 8).
// A cycle-level reference model computes busy/done/sum/cout from plain
// arithmetic (a+b+cin) and a remaining-cycles count; a compare process
// checks the DUT against it on every falling edge after reset. Directed
// tasks add hand-computed literal expectations for each scenario.
module tb_serial_adder;

    localparam int WIDTH = 8;
    localparam int TIMEOUT = 40;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [1:0]       state_dbg;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .state_dbg (state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic             m_valid = 1'b0;
    logic             m_busy;
    logic             m_done;
    logic [WIDTH-1:0] m_sum;
    logic             m_cout;
    logic [WIDTH:0]   m_pend;
    int               m_left;
    logic [WIDTH:0]   exp_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_sum   = '0;
            m_cout  = 1'b0;
            m_left  = 0;
            exp_q.delete();
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                {m_cout, m_sum} = m_pend;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_pend = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                exp_q.push_back(m_pend);
                m_left = WIDTH;
                m_busy = 1'b1;
            end
        end
    end

    // ---------------- compare process + scoreboard ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("sum",  64'(sum),  64'(m_sum));
            check("cout", 64'(cout), 64'(m_cout));
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_done", 64'(1), 64'(0));
                end else begin
                    check("sb_result", 64'({cout, sum}), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Wait for done, returning the number of falling edges seen (0 on timeout).
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cycles = k;
                break;
            end
        end
        if (cycles == 0) check("done_timeout", 64'(0), 64'(1));
    endtask

    // Single operation; start is driven for one cycle, operands scrambled afterwards.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tc, input logic [WIDTH-1:0] esum,
                          input logic ecout, input string name);
        int cyc;
        start = 1'b1; a = ta; b = tb; cin = tc;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom_range(0, 255));
        b = WIDTH'($urandom_range(0, 255));
        cin = 1'(($urandom_range(0, 1)));
        check({name, "_busy"}, 64'(busy), 64'(1));
        wait_done(cyc);
        // start sampled on the edge before the first falling edge: done is seen
        // on falling edge WIDTH+1 counted from the one where start was driven.
        check({name, "_latency"}, 64'(cyc + 1), 64'(WIDTH + 1));
        check({name, "_sum"}, 64'(sum), 64'(esum));
        check({name, "_cout"}, 64'(cout), 64'(ecout));
        @(negedge clk);
        check({name, "_done_1cyc"}, 64'(done), 64'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_sum",  64'(sum),  64'(0));
        check("rst_cout", 64'(cout), 64'(0));

        // First edge with rst low accepts start.
        rst = 1'b0;
        run_op(8'h35, 8'h0A, 1'b0, 8'h3F, 1'b0, "basic");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "chain1");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "chain2");
        run_op(8'h05, ~8'h07, 1'b1, 8'hFE, 1'b0, "sub_borrow");
        run_op(8'h07, ~8'h05, 1'b1, 8'h02, 1'b1, "sub_ok");

        // Busy: re-pulse start with new operands mid-run; must be ignored.
        start = 1'b1; a = 8'h21; b = 8'h43; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'hF0; b = 8'h0F; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_hold_sum", 64'(sum), 64'(8'h02));
        check("busy_hold_cout", 64'(cout), 64'(1));
        wait_done(cyc);
        check("busy_latency", 64'(cyc + 4), 64'(WIDTH + 1));
        check("busy_sum", 64'(sum), 64'(8'h65));
        check("busy_cout", 64'(cout), 64'(0));
        repeat (2) @(negedge clk);

        // Back-to-back: start held high, operands swapped during each DONE.
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        wait_done(cyc);
        check("b2b0_sum", 64'(sum), 64'(8'h46));
        check("b2b0_cout", 64'(cout), 64'(0));
        a = 8'h80; b = 8'h80; cin = 1'b1;
        wait_done(cyc);
        check("b2b1_period", 64'(cyc), 64'(WIDTH + 1));
        check("b2b1_sum", 64'(sum), 64'(8'h01));
        check("b2b1_cout", 64'(cout), 64'(1));
        a = 8'hAA; b = 8'h55; cin = 1'b1;
        wait_done(cyc);
        check("b2b2_period", 64'(cyc), 64'(WIDTH + 1));
        check("b2b2_sum", 64'(sum), 64'(8'h00));
        check("b2b2_cout", 64'(cout), 64'(1));
        start = 1'b0;
        repeat (WIDTH + 3) @(negedge clk);

        // Reset on the 4th RUN cycle aborts silently.
        start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_sum",  64'(sum),  64'(0));
        check("abort_cout", 64'(cout), 64'(0));
        rst = 1'b0;
        cyc = 0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            @(negedge clk);
            if (done === 1'b1) cyc++;
        end
        check("abort_no_done", 64'(cyc), 64'(0));
        run_op(8'h9C, 8'h64, 1'b0, 8'h00, 1'b1, "after_abort");
        run_op(8'h01, 8'h02, 1'b1, 8'h04, 1'b0, "small");

        repeat (2) @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
